// File: rtl/hack_cpu_ctrl_if.sv
// ROM, data-memory and ALU signal bundle between the Hack sequencer (master) and its environment (slave).
interface hack_cpu_ctrl_if #(
  parameter int ADDR_W = 15
);
  logic [ADDR_W-1:0] rom_addr;
  logic [15:0]       rom_data;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;
  logic [15:0]       mem_rdata;
  logic              mem_ack;
  logic [15:0]       alu_x;
  logic [15:0]       alu_y;
  logic              alu_zx;
  logic              alu_nx;
  logic              alu_zy;
  logic              alu_ny;
  logic              alu_f;
  logic              alu_no;
  logic [15:0]       alu_out;
  logic              alu_zr;
  logic              alu_ng;

  modport master (
    output rom_addr,
    input  rom_data,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack,
    output alu_x, alu_y, alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no,
    input  alu_out, alu_zr, alu_ng
  );

  modport slave (
    input  rom_addr,
    output rom_data,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack,
    input  alu_x, alu_y, alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no,
    output alu_out, alu_zr, alu_ng
  );
endinterface

// File: rtl/hack_cpu_ctrl.sv
// Multicycle Hack CPU sequencer: fetch/decode, A/D/PC state, ALU control, req/ack data-memory port.
// Optional self-loop halt detector is enabled by defining HACK_CTRL_HALT_DET_EN.
module hack_cpu_ctrl #(
  parameter int                ADDR_W   = 15,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  hack_cpu_ctrl_if.master   bus,
  output logic [ADDR_W-1:0] pc,
  output logic [15:0]       a_reg,
  output logic [15:0]       d_reg,
  output logic              instr_done,
  output logic              halted
);

`ifdef HACK_CTRL_HALT_DET_EN
  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_READ_M, S_EXEC, S_WRITE_M, S_HALT} state_t;
`else
  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_READ_M, S_EXEC, S_WRITE_M} state_t;
`endif

  state_t            state;
  state_t            state_nx;
  logic [15:0]       ir;
  logic [15:0]       m_q;
  logic [15:0]       r_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] pc_inc;
  logic              zr_q;
  logic              ng_q;
  logic              retire;
  logic              take_jump;
  logic              jmp_exec;
  logic              jmp_wr;
  logic [5:0]        alu_ctl;
  logic              unused_ir;

  assign unused_ir = ^ir[15:13];
  assign pc_inc    = pc + ADDR_W'(1);

  // EXEC resolves on the live ALU flags; WRITE_M resolves later on the flags latched in EXEC.
  assign jmp_exec = (ir[2] & bus.alu_ng) | (ir[1] & bus.alu_zr) | (ir[0] & ~bus.alu_ng & ~bus.alu_zr);
  assign jmp_wr   = (ir[2] & ng_q) | (ir[1] & zr_q) | (ir[0] & ~ng_q & ~zr_q);

  always_comb begin
    state_nx    = state;
    retire      = 1'b0;
    take_jump   = 1'b0;
    alu_ctl     = 6'b0;
    bus.mem_req = 1'b0;
    bus.mem_we  = 1'b0;
    case (state)
      S_FETCH: state_nx = S_DECODE;
      S_DECODE: begin
        if (!bus.rom_data[15])
          retire = 1'b1;
        else if (bus.rom_data[12])
          state_nx = S_READ_M;
        else
          state_nx = S_EXEC;
      end
      S_READ_M: begin
        bus.mem_req = 1'b1;
        if (bus.mem_ack)
          state_nx = S_EXEC;
      end
      S_EXEC: begin
        alu_ctl = ir[11:6];
        if (ir[3]) begin
          state_nx = S_WRITE_M;
        end else begin
          retire    = 1'b1;
          take_jump = jmp_exec;
        end
      end
      S_WRITE_M: begin
        bus.mem_req = 1'b1;
        bus.mem_we  = 1'b1;
        if (bus.mem_ack) begin
          retire    = 1'b1;
          take_jump = jmp_wr;
        end
      end
`ifdef HACK_CTRL_HALT_DET_EN
      S_HALT: state_nx = S_HALT;
`endif
      default: state_nx = S_FETCH;
    endcase
    if (retire) begin
      state_nx = S_FETCH;
`ifdef HACK_CTRL_HALT_DET_EN
      if (take_jump && (addr_q == pc))
        state_nx = S_HALT;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      state <= S_FETCH;
    else
      state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc         <= RESET_PC;
      a_reg      <= 16'h0;
      d_reg      <= 16'h0;
      ir         <= 16'h0;
      addr_q     <= '0;
      m_q        <= 16'h0;
      r_q        <= 16'h0;
      zr_q       <= 1'b0;
      ng_q       <= 1'b0;
      instr_done <= 1'b0;
    end else begin
      instr_done <= retire;
      if (retire)
        pc <= take_jump ? addr_q : pc_inc;
      case (state)
        S_DECODE: begin
          ir     <= bus.rom_data;
          // addr_q keeps the pre-instruction A so a dest-A write never redirects the access or jump
          addr_q <= a_reg[ADDR_W-1:0];
          if (!bus.rom_data[15])
            a_reg <= {1'b0, bus.rom_data[14:0]};
        end
        S_READ_M: begin
          if (bus.mem_ack)
            m_q <= bus.mem_rdata;
        end
        S_EXEC: begin
          r_q  <= bus.alu_out;
          zr_q <= bus.alu_zr;
          ng_q <= bus.alu_ng;
          if (ir[4])
            d_reg <= bus.alu_out;
          if (ir[5])
            a_reg <= bus.alu_out;
        end
        default: ;
      endcase
    end
  end

  assign bus.rom_addr  = pc;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = r_q;
  assign bus.alu_x     = d_reg;
  assign bus.alu_y     = ir[12] ? m_q : a_reg;
  assign {bus.alu_zx, bus.alu_nx, bus.alu_zy, bus.alu_ny, bus.alu_f, bus.alu_no} = alu_ctl;

`ifdef HACK_CTRL_HALT_DET_EN
  assign halted = (state == S_HALT);
`else
  assign halted = 1'b0;
`endif

endmodule
